// File: rtl/truth_table_sweep_checker_if.sv
//============================================================================
// Module   : truth_table_sweep_checker_if
// Purpose  : Bundles the control, table-load, DUT-facing and status signals
//            of truth_table_sweep_checker into one interface.
// Ports    : start, tbl_we, tbl_addr, tbl_data  - control / table load
//            o_x, i_y_dknf, i_y_ddnf            - vector out, DUT results in
//            busy, done, pass, err_count, err_vec,
//            first_err_valid/addr/src           - status
// Modports : master - the environment (drives control and DUT results)
//            slave  - the checker itself
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

interface truth_table_sweep_checker_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 5
);
    logic             start;
    logic             tbl_we;
    logic [IN_W-1:0]  tbl_addr;
    logic [OUT_W-1:0] tbl_data;
    logic [IN_W-1:0]  o_x;
    logic [OUT_W-1:0] i_y_dknf;
    logic [OUT_W-1:0] i_y_ddnf;
    logic             busy;
    logic             done;
    logic             pass;
    logic [IN_W:0]    err_count;
    logic             err_vec;
    logic             first_err_valid;
    logic [IN_W-1:0]  first_err_addr;
    logic [1:0]       first_err_src;

    modport master (
        output start, tbl_we, tbl_addr, tbl_data, i_y_dknf, i_y_ddnf,
        input  o_x, busy, done, pass, err_count, err_vec,
               first_err_valid, first_err_addr, first_err_src
    );

    modport slave (
        input  start, tbl_we, tbl_addr, tbl_data, i_y_dknf, i_y_ddnf,
        output o_x, busy, done, pass, err_count, err_vec,
               first_err_valid, first_err_addr, first_err_src
    );
endinterface

`default_nettype wire

// File: rtl/truth_table_sweep_checker.sv
//============================================================================
// Module   : truth_table_sweep_checker
// Purpose  : On-hardware exhaustive checker for the DDNF/DKNF logic pair.
//            Sweeps o_x over 0 .. 2^IN_W-1, holds each vector SETTLE cycles,
//            then compares both implementations' outputs against an
//            expected truth table held in an internal RAM. Reports the
//            mismatch count, the first failing vector and pass/fail.
// Ports    : clk, rst (async, active-high)
//            bus (slave modport of truth_table_sweep_checker_if):
//              start            - one-cycle pulse, starts a sweep (IDLE/DONE)
//              tbl_we/addr/data - expected-table write port (IDLE/DONE only)
//              o_x              - vector driven to both implementations
//              i_y_dknf/ddnf    - implementation results
//              busy/done/pass   - sweep status, pass valid with done
//              err_count        - mismatching vectors (IN_W+1 bits)
//              err_vec          - high during a mismatching compare cycle
//              first_err_*      - vector and source of the first mismatch
// Options  : STOP_ON_ERROR_EN - when defined, the first mismatch ends the
//            sweep with o_x frozen at the failing vector.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module truth_table_sweep_checker #(
    parameter int IN_W   = 8,
    parameter int OUT_W  = 5,
    parameter int SETTLE = 2      // 1..15 cycles of hold before sampling
) (
    input  logic                        clk,
    input  logic                        rst,
    truth_table_sweep_checker_if.slave  bus
);

    localparam logic [IN_W-1:0] c_x_last = '1;
    localparam logic [3:0]      c_settle = 4'(SETTLE);

`ifdef STOP_ON_ERROR_EN
    localparam bit c_stop_on_error = 1'b1;
`else
    localparam bit c_stop_on_error = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HOLD    = 2'd1,
        S_COMPARE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t             r_state;
    logic [IN_W-1:0]    r_x;
    logic [3:0]         r_settle;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [IN_W:0]      r_err_count;
    logic               r_first_valid;
    logic [IN_W-1:0]    r_first_addr;
    logic [1:0]         r_first_src;

    // Expected truth table; deliberately not reset so a table loaded once
    // survives any number of resets and sweeps.
    logic [OUT_W-1:0]   r_tbl [0:(1<<IN_W)-1];
    logic [OUT_W-1:0]   r_rd_data;

    logic               w_table_open;
    logic               w_mism_k;
    logic               w_mism_d;
    logic               w_mism;
    logic [IN_W:0]      w_err_next;

    // Writes only land outside a sweep so the table cannot change under
    // an in-flight comparison.
    assign w_table_open = (r_state == S_IDLE) || (r_state == S_DONE);

    // Synchronous read at the current vector. o_x is stable for at least one
    // HOLD cycle before COMPARE, so r_rd_data is always the entry for o_x by
    // the time it is used. A write issued together with start lands on the
    // start edge and the first read of that address happens a cycle later.
    always_ff @(posedge clk) begin
        if (bus.tbl_we && w_table_open) begin
            r_tbl[bus.tbl_addr] <= bus.tbl_data;
        end
        r_rd_data <= r_tbl[r_x];
    end

    assign w_mism_k   = (bus.i_y_dknf != r_rd_data);
    assign w_mism_d   = (bus.i_y_ddnf != r_rd_data);
    assign w_mism     = (r_state == S_COMPARE) && (w_mism_k || w_mism_d);
    assign w_err_next = r_err_count + (IN_W+1)'(w_mism);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_x           <= '0;
            r_settle      <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_err_count   <= '0;
            r_first_valid <= 1'b0;
            r_first_addr  <= '0;
            r_first_src   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_state       <= S_HOLD;
                        r_x           <= '0;
                        r_settle      <= c_settle;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                        r_pass        <= 1'b0;
                        r_err_count   <= '0;
                        r_first_valid <= 1'b0;
                        r_first_addr  <= '0;
                        r_first_src   <= '0;
                    end
                end

                // Counter runs SETTLE..1, giving SETTLE hold cycles plus the
                // compare cycle: SETTLE+1 cycles per vector.
                S_HOLD: begin
                    r_settle <= r_settle - 4'd1;
                    if (r_settle == 4'd1) begin
                        r_state <= S_COMPARE;
                    end
                end

                S_COMPARE: begin
                    r_err_count <= w_err_next;
                    if (w_mism && !r_first_valid) begin
                        r_first_valid <= 1'b1;
                        r_first_addr  <= r_x;
                        r_first_src   <= {w_mism_d, w_mism_k};
                    end
                    // o_x never wraps: the last vector ends the sweep.
                    if ((r_x == c_x_last) || (c_stop_on_error && w_mism)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == '0);
                    end else begin
                        r_x      <= r_x + IN_W'(1);
                        r_settle <= c_settle;
                        r_state  <= S_HOLD;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_x             = r_x;
    assign bus.busy            = r_busy;
    assign bus.done            = r_done;
    assign bus.pass            = r_pass;
    assign bus.err_count       = r_err_count;
    // Decoded from the registered state so it is high exactly during the
    // compare cycle of a failing vector, aligned with o_x.
    assign bus.err_vec         = w_mism;
    assign bus.first_err_valid = r_first_valid;
    assign bus.first_err_addr  = r_first_addr;
    assign bus.first_err_src   = r_first_src;

endmodule

`default_nettype wire

// File: tb/tb_truth_table_sweep_checker.sv
//============================================================================
// Module   : tb_truth_table_sweep_checker
// Purpose  : Self-checking bench for truth_table_sweep_checker. Models the
//            two logic implementations (with optional fault injection),
//            loads the expected table, runs sweeps from a scenario table
//            and checks results through a scoreboard queue.
// Options  : STOP_ON_ERROR_EN selects the stop-on-first-error expectations.
// Revision : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_truth_table_sweep_checker;

    localparam int IN_W   = 8;
    localparam int OUT_W  = 5;
    localparam int SETTLE = 2;
    localparam int PERIOD = SETTLE + 1;
    localparam int SWEEP  = 256 * PERIOD;   // 768 cycles

    typedef struct {
        int         tbl_mode;   // 0 = table[i]=i[4:0], 1 = all zero, 2 = keep
        int         fault;      // implementation model selector
        int         cnt;        // expected err_count / err_vec pulses
        bit         fvalid;
        logic [7:0] faddr;
        logic [1:0] fsrc;
        bit         pass;
        int         cycles;     // start edge to done rising
        logic [7:0] x_end;      // o_x when done
    } scen_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    truth_table_sweep_checker_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    truth_table_sweep_checker #(
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .SETTLE (SETTLE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         checks = 0;
    int         errors = 0;
    int         pulses = 0;
    int         fault_mode = 0;
    logic [4:0] exp_tbl [256];
    logic [4:0] yk, yd;
    scen_t      sb[$];
    scen_t      vecs[5];

    // Implementation models: both compute y = x[4:0] unless a fault is chosen.
    always_comb begin
        yk = bus.o_x[4:0];
        yd = bus.o_x[4:0];
        case (fault_mode)
            1: if (bus.o_x == 8'h2A) yd = 5'h1F;
            2: begin yk = 5'h01; yd = 5'h01; end
            3: if (bus.o_x == 8'h05) yk = 5'h1F;
            default: ;
        endcase
    end
    assign bus.i_y_dknf = yk;
    assign bus.i_y_ddnf = yd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every err_vec pulse must sit on a vector the bench model says mismatches.
    always @(negedge clk) begin
        if (!rst && bus.err_vec) begin
            pulses++;
            chk("err_vec_on_mismatch",
                32'((yk != exp_tbl[bus.o_x]) || (yd != exp_tbl[bus.o_x])), 32'd1);
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_o_x"},       32'(bus.o_x), 32'd0);
        chk({tag, "_busy"},      32'(bus.busy), 32'd0);
        chk({tag, "_done"},      32'(bus.done), 32'd0);
        chk({tag, "_pass"},      32'(bus.pass), 32'd0);
        chk({tag, "_err_count"}, 32'(bus.err_count), 32'd0);
        chk({tag, "_err_vec"},   32'(bus.err_vec), 32'd0);
        chk({tag, "_fvalid"},    32'(bus.first_err_valid), 32'd0);
        chk({tag, "_faddr"},     32'(bus.first_err_addr), 32'd0);
        chk({tag, "_fsrc"},      32'(bus.first_err_src), 32'd0);
    endtask

    task automatic load_table(input int mode);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            bus.tbl_we   = 1'b1;
            bus.tbl_addr = 8'(i);
            bus.tbl_data = (mode == 0) ? 5'(i) : 5'h00;
            exp_tbl[i]   = (mode == 0) ? 5'(i) : 5'h00;
        end
        @(negedge clk);
        bus.tbl_we = 1'b0;
    endtask

    // poke_at: cycle at which start+tbl_we are pulsed mid-sweep (-1 = never)
    // rst_at : cycle at which reset aborts the sweep (-1 = never)
    // wr0    : write table[0]=1F in the same cycle as start
    task automatic run_sweep(input scen_t s, input int poke_at, input int rst_at, input bit wr0);
        scen_t e;
        int    n;
        fault_mode = s.fault;
        if (s.tbl_mode == 0)      load_table(0);
        else if (s.tbl_mode == 1) load_table(1);
        sb.push_back(s);
        @(negedge clk);
        pulses    = 0;
        bus.start = 1'b1;
        if (wr0) begin
            bus.tbl_we   = 1'b1;
            bus.tbl_addr = 8'h00;
            bus.tbl_data = 5'h1F;
            exp_tbl[0]   = 5'h1F;
        end
        @(negedge clk);
        bus.start  = 1'b0;
        bus.tbl_we = 1'b0;
        n = 0;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        chk("done_after_start", 32'(bus.done), 32'd0);
        while (!bus.done && n < 2000) begin
            if (n == poke_at) begin
                bus.start    = 1'b1;
                bus.tbl_we   = 1'b1;
                bus.tbl_addr = 8'h80;
                bus.tbl_data = 5'h1F;
            end else begin
                bus.start  = 1'b0;
                bus.tbl_we = 1'b0;
            end
            if (n == rst_at) begin
                rst = 1'b1;
                #2;
                check_all_zero("rst_mid_sweep");
                @(negedge clk);
                check_all_zero("rst_held");
                rst = 1'b0;
                void'(sb.pop_front());
                return;
            end
            @(negedge clk);
            n++;
        end
        bus.start  = 1'b0;
        bus.tbl_we = 1'b0;
        chk("done_within_bound", 32'(bus.done), 32'd1);
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk("sweep_cycles",    32'(n),                   32'(e.cycles));
        chk("busy_at_done",    32'(bus.busy),            32'd0);
        chk("pass",            32'(bus.pass),            32'(e.pass));
        chk("err_count",       32'(bus.err_count),       32'(e.cnt));
        chk("first_err_valid", 32'(bus.first_err_valid), 32'(e.fvalid));
        chk("first_err_addr",  32'(bus.first_err_addr),  32'(e.faddr));
        chk("first_err_src",   32'(bus.first_err_src),   32'(e.fsrc));
        chk("o_x_at_done",     32'(bus.o_x),             32'(e.x_end));
        chk("err_vec_pulses",  32'(pulses),              32'(e.cnt));
        @(negedge clk);
        chk("done_held",       32'(bus.done),            32'd1);
    endtask

    initial begin
        scen_t tmp;
        bus.start    = 1'b0;
        bus.tbl_we   = 1'b0;
        bus.tbl_addr = '0;
        bus.tbl_data = '0;

`ifdef STOP_ON_ERROR_EN
        vecs[0] = '{0, 0,   0, 1'b0, 8'h00, 2'b00, 1'b1, SWEEP,          8'hFF};
        vecs[1] = '{2, 1,   1, 1'b1, 8'h2A, 2'b10, 1'b0, 43 * PERIOD,    8'h2A};
        vecs[2] = '{1, 2,   1, 1'b1, 8'h00, 2'b11, 1'b0, 1 * PERIOD,     8'h00};
        vecs[3] = '{0, 3,   1, 1'b1, 8'h05, 2'b01, 1'b0, 6 * PERIOD,     8'h05};
        vecs[4] = '{2, 0,   1, 1'b1, 8'h00, 2'b11, 1'b0, 1 * PERIOD,     8'h00};
`else
        vecs[0] = '{0, 0,   0, 1'b0, 8'h00, 2'b00, 1'b1, SWEEP,          8'hFF};
        vecs[1] = '{2, 1,   1, 1'b1, 8'h2A, 2'b10, 1'b0, SWEEP,          8'hFF};
        vecs[2] = '{1, 2, 256, 1'b1, 8'h00, 2'b11, 1'b0, SWEEP,          8'hFF};
        vecs[3] = '{0, 3,   1, 1'b1, 8'h05, 2'b01, 1'b0, SWEEP,          8'hFF};
        vecs[4] = '{2, 0,   1, 1'b1, 8'h00, 2'b11, 1'b0, SWEEP,          8'hFF};
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("after_reset");

        // Table-driven sweeps: pass, single DDNF fault, all-fail, DKNF fault
        for (int i = 0; i < 4; i++) begin
            run_sweep(vecs[i], -1, -1, 1'b0);
        end

        // start and tbl_we pulsed while busy: both must be ignored
        run_sweep(vecs[0], 100, -1, 1'b0);

        // start + write in the same DONE cycle: vector 0 sees the new entry
        run_sweep(vecs[4], -1, -1, 1'b1);
        @(negedge clk);
        bus.tbl_we   = 1'b1;
        bus.tbl_addr = 8'h00;
        bus.tbl_data = 5'h00;
        exp_tbl[0]   = 5'h00;
        @(negedge clk);
        bus.tbl_we   = 1'b0;

        // Reset mid-sweep, then a sweep on the untouched table must pass
        // (also confirms the busy-time write to 0x80 never landed).
        tmp = vecs[0];
        tmp.tbl_mode = 2;
        run_sweep(tmp, -1, 300, 1'b0);
        chk("sb_empty_after_abort", 32'(sb.size()), 32'd0);
        @(negedge clk);
        run_sweep(tmp, -1, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
